alu_cmd_sequencer: RTL and testbench

Command-queue controller that sequences the team's 8-bit, 16-function ALU datapath against an internal accumulator.
- Requesters push {opcode, operand B, carry-in, writeback} commands through a valid/ready port into a small FIFO.
- The sequencer issues one command at a time with the accumulator as operand A.
- Each result is registered and presented on a valid/ready result port; the accumulator is optionally updated.
- Sits between a bus/command front end and the ALU.

---
 rtl/alu_cmd_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command FIFO feeding a 16-function ALU. The accumulator
// is operand A; every result lands in a valid/ready result register.
// Optional macro ALU_CMD_SEQUENCER_FLAGS_EN adds registered res_zero/res_carry.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_sel,
    input  logic [W-1:0]             cmd_b,
    input  logic                     cmd_cin,
    input  logic                     cmd_wb,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [W-1:0]             res_data,
`ifdef ALU_CMD_SEQUENCER_FLAGS_EN
    output logic                     res_zero,
    output logic                     res_carry,
`endif
    output logic [W-1:0]             acc,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   cmd_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [3:0]   sel;
        logic [W-1:0] b;
        logic         cin;
        logic         wb;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    state_t        state_q, state_d;
    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  acc_q, acc_d, res_data_q, res_data_d;
    logic          res_valid_q, res_valid_d;
    logic          empty, full, push, issue;
    cmd_t          head;
    logic [W-1:0]  a, b, y;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign push      = cmd_valid && !full;
    assign head      = mem_q[rd_ptr_q];
    assign a         = acc_q;
    assign b         = head.b;
    assign cmd_ready = !full;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign acc       = acc_q;
    assign busy      = !empty || res_valid_q;
    assign cmd_count = count_q;

    // ALU: result of the head command against the current accumulator
    always_comb begin
        y = '0;
        case (head.sel)
            4'h0: y = a;
            4'h1: y = a + W'(1);
            4'h2: y = a - W'(1);
            4'h3: y = b;
            4'h4: y = b + W'(1);
            4'h5: y = b - W'(1);
            4'h6: y = a + b;
            4'h7: y = a + b + W'(head.cin);
            4'h8: y = ~a;
            4'h9: y = ~b;
            4'hA: y = a & b;
            4'hB: y = a | b;
            4'hC: y = ~(a & b);
            4'hD: y = ~(a | b);
            4'hE: y = a ^ b;
            default: y = ~(a ^ b);
        endcase
    end

    // Sequencer FSM, FIFO pointers/occupancy and result/accumulator update
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        acc_d       = acc_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        issue       = 1'b0;
        case (state_q)
            IDLE: if (!empty) state_d = RUN;
            RUN: begin
                if (empty)                            state_d = IDLE;
                else if (!res_valid_q || res_ready)   issue   = 1'b1;
                else                                  state_d = STALL;
            end
            STALL: if (res_ready) begin
                issue   = 1'b1;
                state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
        if (issue) begin
            res_data_d  = y;
            res_valid_d = 1'b1;
            if (head.wb) acc_d = y;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
        if (push)  wr_ptr_d = wr_ptr_q + AW'(1);
        if (issue) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, issue})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{sel: cmd_sel, b: cmd_b, cin: cmd_cin, wb: cmd_wb};
    end

`ifdef ALU_CMD_SEQUENCER_FLAGS_EN
    logic [W:0] ext;
    logic       y_c;
    logic       zero_q, zero_d, carry_q, carry_d;

    // Carry/borrow out of the arithmetic codes, zero for the rest
    always_comb begin
        ext = '0;
        y_c = 1'b0;
        case (head.sel)
            4'h1: begin ext = {1'b0, a} + (W+1)'(1); y_c = ext[W]; end
            4'h4: begin ext = {1'b0, b} + (W+1)'(1); y_c = ext[W]; end
            4'h6: begin ext = {1'b0, a} + {1'b0, b}; y_c = ext[W]; end
            4'h7: begin ext = {1'b0, a} + {1'b0, b} + (W+1)'(head.cin); y_c = ext[W]; end
            4'h2: y_c = (a == '0);
            4'h5: y_c = (b == '0);
            default: y_c = 1'b0;
        endcase
    end

    // Flags load with the result and hold alongside it
    always_comb begin
        zero_d  = zero_q;
        carry_d = carry_q;
        if (issue) begin
            zero_d  = (y == '0);
            carry_d = y_c;
        end
    end

    // Flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    assign res_zero  = zero_q;
    assign res_carry = carry_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a scoreboard of expected results.
module tb_alu_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int W     = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0, cmd_ready;
    logic [3:0]   cmd_sel = '0;
    logic [W-1:0] cmd_b = '0;
    logic         cmd_cin = 1'b0, cmd_wb = 1'b0;
    logic         res_valid, res_ready = 1'b0;
    logic [W-1:0] res_data, acc;
    logic         busy;
    logic [$clog2(DEPTH):0] cmd_count;
`ifdef ALU_CMD_SEQUENCER_FLAGS_EN
    logic         res_zero, res_carry;
`endif

    alu_cmd_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
        .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_wb(cmd_wb),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
`ifdef ALU_CMD_SEQUENCER_FLAGS_EN
        .res_zero(res_zero), .res_carry(res_carry),
`endif
        .acc(acc), .busy(busy), .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       z;
        logic       c;
    } exp_t;

    exp_t       q[$];
    exp_t       cur;
    logic [7:0] m_acc = '0;
    int         total = 0;
    int         bad   = 0;
    int         n_res = 0;

    function automatic exp_t model(logic [3:0] s, logic [7:0] a, logic [7:0] b, logic ci);
        exp_t e;
        logic [8:0] t;
        e.c = 1'b0;
        e.d = '0;
        t   = '0;
        case (s)
            4'h0: e.d = a;
            4'h1: begin t = {1'b0, a} + 9'd1; e.d = t[7:0]; e.c = t[8]; end
            4'h2: begin e.d = a - 8'd1; e.c = (a == 8'd0); end
            4'h3: e.d = b;
            4'h4: begin t = {1'b0, b} + 9'd1; e.d = t[7:0]; e.c = t[8]; end
            4'h5: begin e.d = b - 8'd1; e.c = (b == 8'd0); end
            4'h6: begin t = {1'b0, a} + {1'b0, b}; e.d = t[7:0]; e.c = t[8]; end
            4'h7: begin t = {1'b0, a} + {1'b0, b} + {8'd0, ci}; e.d = t[7:0]; e.c = t[8]; end
            4'h8: e.d = ~a;
            4'h9: e.d = ~b;
            4'hA: e.d = a & b;
            4'hB: e.d = a | b;
            4'hC: e.d = ~(a & b);
            4'hD: e.d = ~(a | b);
            4'hE: e.d = a ^ b;
            default: e.d = ~(a ^ b);
        endcase
        e.z = (e.d == 8'd0);
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: score the result handshake and record an accepted command.
    task automatic cyc();
        exp_t e;
        if (!rst && res_valid && res_ready) begin
            n_res++;
            if (q.size() == 0) chk("res_extra", 32'(q.size()), 32'd1);
            else begin
                e = q.pop_front();
                chk("res_data", 32'(res_data), 32'(e.d));
`ifdef ALU_CMD_SEQUENCER_FLAGS_EN
                chk("res_zero", 32'(res_zero), 32'(e.z));
                chk("res_carry", 32'(res_carry), 32'(e.c));
`endif
            end
        end
        if (!rst && cmd_valid && cmd_ready) begin
            q.push_back(cur);
            if (cmd_wb) m_acc = cur.d;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [3:0] s, logic [7:0] b, logic ci, logic wb, bit k_en, logic [7:0] k);
        cmd_sel   = s;
        cmd_b     = b;
        cmd_cin   = ci;
        cmd_wb    = wb;
        cmd_valid = 1'b1;
        cur = model(s, m_acc, b, ci);
        if (k_en) begin
            cur.d = k;
            cur.z = (k == 8'd0);
        end
    endtask

    task automatic send(logic [3:0] s, logic [7:0] b, logic ci, logic wb, bit k_en = 0, logic [7:0] k = 0);
        logic took;
        took = 1'b0;
        drive(s, b, ci, wb, k_en, k);
        for (int i = 0; i < 64; i++) begin
            took = cmd_ready;
            cyc();
            if (took) break;
        end
        chk("send_accept", 32'(took), 32'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic drain(int limit);
        for (int i = 0; i < limit && q.size() > 0; i++) cyc();
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] ktab [8];
        int         n0;
        logic       took;
        ktab = '{8'h0F, 8'hC3, 8'h30, 8'hFC, 8'hCF, 8'h03, 8'hCC, 8'h33};

        // Reset values
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_count", 32'(cmd_count), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_acc", 32'(acc), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Load B, two-edge latency from IDLE
        res_ready = 1'b1;
        send(4'h3, 8'h5A, 1'b0, 1'b1);
        chk("lat_e0", 32'(res_valid), 32'd0);
        cyc();
        chk("lat_e1", 32'(res_valid), 32'd0);
        cyc();
        chk("lat_e2", 32'(res_valid), 32'd1);
        chk("lat_acc", 32'(acc), 32'h5A);
        drain(20);

        // Add with wrap, then add-with-carry without writeback
        send(4'h6, 8'hB0, 1'b0, 1'b1);
        send(4'h7, 8'h00, 1'b1, 1'b0);
        drain(20);
        chk("adc_acc", 32'(acc), 32'h0A);

        // Fill with the consumer stalled
        res_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) send(4'h4, 8'(i * 17), 1'b0, 1'b0);
        n0 = n_res;
        drive(4'h5, 8'h80, 1'b0, 1'b0, 0, 8'h00);
        repeat (3) cyc();
        chk("full_ready", 32'(cmd_ready), 32'd0);
        chk("full_count", 32'(cmd_count), 32'(DEPTH));
        chk("full_res_valid", 32'(res_valid), 32'd1);
        chk("full_hold", 32'(res_data), 32'(q[0].d));
        chk("full_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 80; i++) begin
            if (q.size() == 0 && !cmd_valid) break;
            res_ready = i[0];
            took = cmd_valid && cmd_ready;
            cyc();
            if (took) cmd_valid = 1'b0;
        end
        chk("fill_drain", 32'(q.size()), 32'd0);
        chk("fill_n_res", 32'(n_res - n0), 32'(DEPTH + 2));
        res_ready = 1'b1;

        // Logic sweep against A=F0, B=3C
        send(4'h3, 8'hF0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) send(4'(8 + i), 8'h3C, 1'b0, 1'b0, 1, ktab[i]);
        drain(40);
        chk("sweep_acc", 32'(acc), 32'hF0);

        // Increment/decrement wrap
        send(4'h3, 8'hFF, 1'b0, 1'b1);
        send(4'h1, 8'h00, 1'b0, 1'b1);
        send(4'h2, 8'h00, 1'b0, 1'b1);
        drain(20);
        chk("wrap_acc", 32'(acc), 32'hFF);

        // Reset with queued commands and a pending result
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(4'h3, 8'(i + 1), 1'b0, 1'b1);
        chk("pre_rst_count", 32'(cmd_count), 32'd3);
        chk("pre_rst_valid", 32'(res_valid), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        q.delete();
        m_acc = '0;
        chk("mid_rst_count", 32'(cmd_count), 32'd0);
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_acc", 32'(acc), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);

        // Operation resumes from a clean accumulator
        res_ready = 1'b1;
        send(4'h1, 8'h00, 1'b0, 1'b1);
        drain(20);
        chk("post_rst_acc", 32'(acc), 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
